// File: rtl/fhn_pkg.sv
// Shared Q3.12 constants and types for the FHN spike detector slice.
package fhn_pkg;

    localparam int unsigned FHN_DATA_W = 16;
    localparam int unsigned FHN_FRAC   = 12;
    localparam int          FHN_ONE    = 4096;
    localparam int unsigned FHN_TS_W   = 32;
    localparam int unsigned FHN_ISI_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        REFRAC
    } det_state_t;

    typedef struct packed {
        logic [FHN_TS_W-1:0]  ts;
        logic [FHN_ISI_W-1:0] isi;
        logic                 first;
    } spike_evt_t;

endpackage

// File: rtl/fhn_spike_detector_if.sv
// Valid/ready event stream carrying timestamped spike events.
interface fhn_spike_detector_if
    import fhn_pkg::*;
#(
    parameter int unsigned TS_W  = FHN_TS_W,
    parameter int unsigned ISI_W = FHN_ISI_W
);
    logic             valid;
    logic             ready;
    logic [TS_W-1:0]  ts;
    logic [ISI_W-1:0] isi;
    logic             first;

    modport master (output valid, ts, isi, first, input ready);
    modport slave  (input valid, ts, isi, first, output ready);
endinterface

// File: rtl/fhn_evt_fifo.sv
// Synchronous show-ahead FIFO; a push while full is dropped unless a pop frees a slot that cycle.
module fhn_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fhn_spike_detector.sv
// Hysteresis/refractory spike detector on the FHN membrane voltage; queues {ts, isi, first} events.
module fhn_spike_detector
    import fhn_pkg::*;
#(
    parameter int unsigned              DATA_W     = FHN_DATA_W,
    parameter int unsigned              FRAC_BITS  = FHN_FRAC,
    parameter logic signed [DATA_W-1:0] V_TH_HI    = DATA_W'(1) << FRAC_BITS,
    parameter logic signed [DATA_W-1:0] V_TH_LO    = '0,
    parameter int unsigned              REFRAC_CYC = 16,
    parameter int unsigned              TS_W       = FHN_TS_W,
    parameter int unsigned              ISI_W      = FHN_ISI_W,
    parameter int unsigned              FIFO_DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] v_in,
    input  logic                     v_valid,
    input  logic                     clr_stats,
    output logic                     spike,
    output logic [15:0]              spike_cnt,
    output logic                     overflow,
    fhn_spike_detector_if.master     evt
);
    localparam int unsigned RF_W = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC) : 1;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [ISI_W-1:0] isi;
        logic             first;
    } evt_t;

    det_state_t       state;
    det_state_t       state_nxt;
    logic [TS_W-1:0]  ts_ctr;
    logic [ISI_W-1:0] isi_ctr;
    logic             have_prior;
    logic [RF_W-1:0]  rf_ctr;
    logic             spike_det;
    logic             enter_refrac;
    logic             first_evt;
    evt_t             push_evt;
    evt_t             head_evt;
    logic             fifo_full_unused;
    logic             fifo_empty;
    logic             fifo_drop;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (v_valid && (v_in >= V_TH_HI)) state_nxt = ARMED;
            ARMED:   if (v_valid && (v_in < V_TH_LO))
                         state_nxt = (REFRAC_CYC == 0) ? IDLE : REFRAC;
            REFRAC:  if (v_valid && (rf_ctr == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spike_det    = (state == IDLE) && v_valid && (v_in >= V_TH_HI);
        enter_refrac = (state == ARMED) && (state_nxt == REFRAC);
    end

    // A clear coincident with a spike makes that spike the new "first".
    assign first_evt      = !have_prior || clr_stats;
    assign push_evt.ts    = ts_ctr;
    assign push_evt.isi   = first_evt ? '0 : isi_ctr;
    assign push_evt.first = first_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_ctr     <= '0;
            isi_ctr    <= '0;
            have_prior <= 1'b0;
            rf_ctr     <= '0;
            spike      <= 1'b0;
            spike_cnt  <= '0;
            overflow   <= 1'b0;
        end else begin
            ts_ctr <= ts_ctr + 1'b1;
            spike  <= spike_det;

            if (spike_det)             isi_ctr <= ISI_W'(1);
            else if (isi_ctr != '1)    isi_ctr <= isi_ctr + 1'b1;

            if (spike_det)             have_prior <= 1'b1;
            else if (clr_stats)        have_prior <= 1'b0;

            if (enter_refrac)          rf_ctr <= RF_W'(REFRAC_CYC - 1);
            else if (rf_ctr != '0)     rf_ctr <= rf_ctr - 1'b1;

            if (clr_stats)             spike_cnt <= {15'b0, spike_det};
            else if (spike_det && (spike_cnt != '1)) spike_cnt <= spike_cnt + 1'b1;

            overflow <= fifo_drop || (overflow && !clr_stats);
        end
    end

    fhn_evt_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (spike_det),
        .din   (push_evt),
        .pop   (evt.ready),
        .dout  (head_evt),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign evt.valid = !fifo_empty;
    assign evt.ts    = head_evt.ts;
    assign evt.isi   = head_evt.isi;
    assign evt.first = head_evt.first;

endmodule
